// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI-lite channel bundle (AR/R/AW/W/B, no rresp, 2-bit bresp) used on both
// sides of the 2:1 arbiter. The master modport is the side that issues
// requests. The slave modport is the side that answers them.
interface axi_lite_arbiter_2to1_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// 2:1 AXI-lite arbiter. M0 is the fetch unit and only reads. M1 is the
// load/store unit and both reads and writes. The single slave is the shared
// RAM port. Only one transaction is outstanding at a time. Ties are broken
// round-robin. An IDLE bubble separates consecutive transactions.
// Optional build macro ARB_STATS_EN adds per-master completion counters and
// a contention (wait) cycle counter.
module axi_lite_arbiter_2to1 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_arbiter_2to1_if.slave  m0,
  axi_lite_arbiter_2to1_if.slave  m1,
  axi_lite_arbiter_2to1_if.master s
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]            stat_m0_cnt,
  output logic [31:0]            stat_m1_cnt,
  output logic [31:0]            stat_wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RD_M0, RD_M1, WR_M1} state_t;

  state_t            state, state_next;
  logic              last_grant, last_grant_next;
  logic              ar_done, aw_done, w_done;
  logic              req0, req1;
  logic [ADDR_W-1:0] ar_addr_sel;
  logic [DATA_W-1:0] rd_data_sel;
  logic              unused_m0_wr;

  assign req0 = m0.arvalid;
  assign req1 = m1.awvalid | m1.arvalid;

  // M0 never writes, so its write-side inputs are intentionally ignored.
  assign unused_m0_wr = ^{m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready};

  // State, grant history and per-channel handshake-done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      if (state == IDLE) begin
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (s.arvalid && s.arready) ar_done <= 1'b1;
        if (s.awvalid && s.awready) aw_done <= 1'b1;
        if (s.wvalid  && s.wready)  w_done  <= 1'b1;
      end
    end
  end

  // Grant decision and combinational routing of the granted master's channels.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    ar_addr_sel     = '0;
    rd_data_sel     = '0;

    m0.arready = 1'b0; m0.rdata = '0; m0.rvalid = 1'b0;
    m0.awready = 1'b0; m0.wready = 1'b0; m0.bresp = '0; m0.bvalid = 1'b0;
    m1.arready = 1'b0; m1.rdata = '0; m1.rvalid = 1'b0;
    m1.awready = 1'b0; m1.wready = 1'b0; m1.bresp = '0; m1.bvalid = 1'b0;
    s.arvalid = 1'b0; s.rready = 1'b0;
    s.awaddr  = '0;   s.awvalid = 1'b0;
    s.wdata   = '0;   s.wstrb   = '0; s.wvalid = 1'b0; s.bready = 1'b0;

    case (state)
      IDLE: begin
        // M0 wins when alone, or on a tie when M1 had the previous grant.
        if (req0 && (!req1 || last_grant)) begin
          state_next      = RD_M0;
          last_grant_next = 1'b0;
        end else if (req1) begin
          state_next      = m1.awvalid ? WR_M1 : RD_M1;
          last_grant_next = 1'b1;
        end
      end
      RD_M0: begin
        ar_addr_sel = m0.araddr;
        s.arvalid   = m0.arvalid & ~ar_done;
        m0.arready  = s.arready & ~ar_done;
        rd_data_sel = s.rdata;
        m0.rdata    = rd_data_sel;
        m0.rvalid   = s.rvalid;
        s.rready    = m0.rready;
        if (s.rvalid && m0.rready) state_next = IDLE;
      end
      RD_M1: begin
        ar_addr_sel = m1.araddr;
        s.arvalid   = m1.arvalid & ~ar_done;
        m1.arready  = s.arready & ~ar_done;
        rd_data_sel = s.rdata;
        m1.rdata    = rd_data_sel;
        m1.rvalid   = s.rvalid;
        s.rready    = m1.rready;
        if (s.rvalid && m1.rready) state_next = IDLE;
      end
      WR_M1: begin
        s.awaddr   = m1.awaddr;
        s.awvalid  = m1.awvalid & ~aw_done;
        m1.awready = s.awready & ~aw_done;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid & ~w_done;
        m1.wready  = s.wready & ~w_done;
        m1.bresp   = s.bresp;
        m1.bvalid  = s.bvalid;
        s.bready   = m1.bready;
        if (s.bvalid && m1.bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    s.araddr = ar_addr_sel;
  end

`ifdef ARB_STATS_EN
  // Completed transactions per master, plus cycles lost to the other master's grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_m0_cnt   <= '0;
      stat_m1_cnt   <= '0;
      stat_wait_cnt <= '0;
    end else begin
      if (state == RD_M0 && s.rvalid && s.rready)
        stat_m0_cnt <= stat_m0_cnt + 32'd1;
      if ((state == RD_M1 && s.rvalid && s.rready) ||
          (state == WR_M1 && s.bvalid && s.bready))
        stat_m1_cnt <= stat_m1_cnt + 32'd1;
      if (((state == RD_M1 || state == WR_M1) && req0) || (state == RD_M0 && req1))
        stat_wait_cnt <= stat_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
